// File: rtl/mux_src_pipe_reg.sv
// mux_src_pipe_reg: registered bundle stage with a 2-entry skid that feeds the 32-bit 4:1 source mux.
// Optional stall counter port (stall_cnt) is built when MUX_SRC_PIPE_STALL_CNT_EN is defined.
module mux_src_pipe_reg #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    // Handshake: a bundle moves on a rising edge where valid & ready are both high; a
    // producer holds valid and its data until that edge, and ready never depends on valid.
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [WIDTH-1:0] in_src0,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    input  logic [WIDTH-1:0] in_src3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] out_sel,
    output logic [WIDTH-1:0] out_src0,
    output logic [WIDTH-1:0] out_src1,
    output logic [WIDTH-1:0] out_src2,
    output logic [WIDTH-1:0] out_src3,
    output logic [1:0]       dbg_state_o
`ifdef MUX_SRC_PIPE_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    // Encoding equals the number of bundles held.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             ld_main_in;
    logic             ld_main_skid;
    logic             ld_skid;

    logic [SEL_W-1:0] main_sel_q;
    logic [WIDTH-1:0] main_src_q [4];
    logic [SEL_W-1:0] skid_sel_q;
    logic [WIDTH-1:0] skid_src_q [4];
    logic [WIDTH-1:0] in_src     [4];

    assign in_src[0] = in_src0;
    assign in_src[1] = in_src1;
    assign in_src[2] = in_src2;
    assign in_src[3] = in_src3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush wins over every handshake: nothing is loaded and the stage empties.
    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_valid) begin
                        ld_main_in = 1'b1;
                        state_d    = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            ld_main_in = 1'b1;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end else if (in_valid) begin
                        ld_skid = 1'b1;
                        state_d = ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        ld_main_skid = 1'b1;
                        state_d      = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_sel_q <= '0;
            for (int i = 0; i < 4; i++) begin
                main_src_q[i] <= '0;
            end
        end else if (ld_main_in) begin
            main_sel_q <= in_sel;
            for (int i = 0; i < 4; i++) begin
                main_src_q[i] <= in_src[i];
            end
        end else if (ld_main_skid) begin
            main_sel_q <= skid_sel_q;
            for (int i = 0; i < 4; i++) begin
                main_src_q[i] <= skid_src_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_sel_q <= '0;
            for (int i = 0; i < 4; i++) begin
                skid_src_q[i] <= '0;
            end
        end else if (ld_skid) begin
            skid_sel_q <= in_sel;
            for (int i = 0; i < 4; i++) begin
                skid_src_q[i] <= in_src[i];
            end
        end
    end

    // Both handshake outputs decode the state flop only, so out_ready never reaches in_ready.
    assign in_ready    = (state_q != ST_SKID);
    assign out_valid   = (state_q != ST_EMPTY);
    assign out_sel     = main_sel_q;
    assign out_src0    = main_src_q[0];
    assign out_src1    = main_src_q[1];
    assign out_src2    = main_src_q[2];
    assign out_src3    = main_src_q[3];
    assign dbg_state_o = state_q;

`ifdef MUX_SRC_PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/mux_src_pipe_reg.md
Name: mux_src_pipe_reg

Overview:
- Registered pipeline stage directly upstream of the 32-bit 4:1 source mux in the CLB datapath.
- Captures four 32-bit candidate sources and the 2-bit select as one bundle, and presents them to the mux.
- Valid/ready handshake on both sides, with a 2-entry skid so back-pressure costs no bubbles.
- Synchronous flush discards in-flight bundles on a pipeline redirect.

Parameters:
- WIDTH, 32, width of each candidate source.
- SEL_W, 2, width of the select field. Fixed at 2 for the 4:1 mux.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous flush; drops all held bundles.
- in_valid  input  1  upstream bundle valid.
- in_ready  output  1  stage can accept a bundle this cycle.
- in_sel  input  SEL_W  select for this bundle.
- in_src0..in_src3  input  WIDTH each  candidate sources.
- out_valid  output  1  bundle presented to the mux is valid.
- out_ready  input  1  mux consumer accepts the bundle.
- out_sel  output  SEL_W  registered select, drives the mux sel.
- out_src0..out_src3  output  WIDTH each  registered sources, drive mux in0..in3.

Behaviour:
- Transfers: input transfer when in_valid & in_ready at a clk edge; output transfer when out_valid & out_ready.
- Storage: main register (drives outputs) plus skid register. in_ready = !skid_valid, driven from a flop, no combinational path from out_ready.
- Reset (rst_n low, async):
  - main_valid = skid_valid = 0, so out_valid = 0.
  - in_ready = 1.
  - out_sel = 0, out_src0..3 = 0, skid data = 0.
- States: EMPTY (main invalid), FULL (main valid, skid empty), SKID (both valid).
- EMPTY:
  - in_valid -> main loads the bundle -> FULL.
  - Otherwise stay in EMPTY.
- FULL:
  - out_ready & in_valid -> main reloads; stay FULL (1 bundle/cycle throughput).
  - out_ready & !in_valid -> EMPTY.
  - !out_ready & in_valid -> skid captures the bundle -> SKID; in_ready = 0 next cycle.
  - !out_ready & !in_valid -> hold.
- SKID:
  - in_ready = 0; inputs ignored.
  - out_ready -> main <= skid, skid_valid = 0 -> FULL.
- Latency: bundle accepted at edge N appears on out_* with out_valid = 1 after edge N (1 cycle) when the stage is EMPTY or draining.
- Ordering: strict FIFO. Skid contents are never presented ahead of main.
- Stability: while out_valid & !out_ready, out_sel and out_src0..3 hold exactly.
- Flush:
  - Highest priority; overrides all handshakes in that cycle.
  - Next state EMPTY: main_valid = skid_valid = 0, in_ready = 1.
  - Any input or output transfer in the flush cycle is void; the input bundle is dropped.
  - Data registers keep their values. Only the valid bits clear.
- Reset mid-operation: async clear of valids and data regardless of state; outputs change without waiting for a clk edge.
- No arithmetic. Data passes bit-exact; out_sel is never decoded or range-checked (all 4 codes are legal).

Optional Feature:
- Macro: MUX_SRC_PIPE_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt, 32 bits.
  - Increments on every cycle with out_valid & !out_ready.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by rst_n; unaffected by flush.
- Undefined: no port and no counter logic. Datapath behaviour is identical either way.

Test Plan:
- Reset/basic: assert rst_n low mid-run -> out_valid = 0, out_sel = 0, all out_src = 0, in_ready = 1 immediately. Release, drive one bundle {sel=0, src0=AAAA_AAAA, src1=5555_5555, src2=0000_0000, src3=FFFF_FFFF} with out_ready = 1 -> next cycle out_valid = 1 with identical values; mux output = AAAA_AAAA.
- Streaming: 4 back-to-back bundles with sel = 0,1,2,3 and out_ready held 1 -> one output per cycle, same order, in_ready never drops.
- Back-pressure: out_ready = 0 while sending bundles with src0 = CCCC_CCCC then src1 = 7777_7777 -> after the 2nd bundle in_ready = 0 and out_* hold the CCCC_CCCC bundle. Raise out_ready -> CCCC bundle then 7777 bundle on consecutive cycles; in_ready returns to 1.
- Flush: in SKID state pulse flush together with in_valid (src2 = 1111_1111) -> next cycle out_valid = 0, in_ready = 1, and 1111_1111 never appears at the output.
- Hold stability: out_ready = 0 for 10 cycles with in_src3 toggling to 4444_4444 -> out_src3 stays at its registered value for all 10 cycles.
- Optional feature (macro defined): 7 stalled cycles, a flush, then 3 more stalled cycles -> stall_cnt = 10. Preload the counter to FFFF_FFFE via force and stall 3 cycles -> stall_cnt = FFFF_FFFF.
